// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;

    localparam logic [DATA_W_DEF-1:0] ZeroWord = '0;
    localparam int ADDR_ZERO = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by ID marks and cleared
// by accepted writes or a flush; a same-cycle mark beats any clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = NUM_WR_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     flush,
    output logic [DEPTH-1:0]         pending
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Clears are applied first so that the mark of a newer producer overrides them.
    always_comb begin
        pending_d = pending_q;
        if (run) begin
            if (flush) begin
                pending_d = '0;
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && int'(waddr[j*ADDR_W +: ADDR_W]) != ADDR_ZERO) begin
                    pending_d[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (mark_en && int'(mark_addr) != ADDR_ZERO) begin
                pending_d[mark_addr] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep and hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                run;

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_CLEAR) begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The array has no reset; the sweep zeroes it, and ascending port order lets the highest port win.
    always_comb begin
        regs_d = regs_q;
        if (!run) begin
            regs_d[idx_q] = DATA_W'(ZeroWord);
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && int'(waddr[j*ADDR_W +: ADDR_W]) != ADDR_ZERO) begin
                    regs_d[waddr[j*ADDR_W +: ADDR_W]] = wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .we        (we),
        .waddr     (waddr),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .flush     (flush),
        .pending   (pending)
    );

    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        logic              hit;
        rdata = '0;
        busy  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = raddr[i*ADDR_W +: ADDR_W];
            val = regs_q[ra];
            hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && waddr[j*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    val = wdata[j*DATA_W +: DATA_W];
                end
            end
`endif
            if (run && re[i] && int'(ra) != ADDR_ZERO) begin
                rdata[i*DATA_W +: DATA_W] = val;
                busy[i]                   = pending[ra] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (32 x 32-bit, two read and two write ports).
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic        flush;

    int vectors;
    int miscompares;
    int cycles;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .busy      (busy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        re        = '0;
        raddr     = '0;
        we        = '0;
        waddr     = '0;
        wdata     = '0;
        mark_en   = 1'b0;
        mark_addr = '0;
        flush     = 1'b0;
    endtask

    task automatic apply_write(input int port, input logic [4:0] addr, input logic [31:0] data);
        we[port]             = 1'b1;
        waddr[port*5 +: 5]   = addr;
        wdata[port*32 +: 32] = data;
    endtask

    task automatic apply_read(input int port, input logic [4:0] addr);
        re[port]           = 1'b1;
        raddr[port*5 +: 5] = addr;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic count_sweep(input string tag);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
        check_output(tag, 64'(cycles), 64'd32);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        rst = 1'b0;

        tick();
        tick();
        apply_read(0, 5'd3);
        apply_read(1, 5'd4);
        #1;
        check_output("reset_ready", 64'(ready), 64'd0);
        check_output("reset_rdata", rdata, 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        clear_inputs();

        // Release reset; inject a write, mark and flush at sweep cycle 5
        rst    = 1'b1;
        cycles = 0;
        while (!ready && cycles < 100) begin
            if (cycles == 5) begin
                apply_write(0, 5'd5, 32'h5555_5555);
                mark_en   = 1'b1;
                mark_addr = 5'd5;
                flush     = 1'b1;
                apply_read(0, 5'd5);
                #1;
                check_output("clear_rdata", rdata, 64'd0);
                check_output("clear_busy", 64'(busy), 64'd0);
            end
            tick();
            cycles++;
            clear_inputs();
        end
        check_output("sweep_len", 64'(cycles), 64'd32);
        check_output("sweep_ready", 64'(ready), 64'd1);

        for (int a = 0; a < 32; a += 2) begin
            apply_read(0, 5'(a));
            apply_read(1, 5'(a + 1));
            #1;
            check_output($sformatf("swept_rdata_%0d", a), rdata, 64'd0);
            check_output($sformatf("swept_busy_%0d", a), 64'(busy), 64'd0);
        end
        clear_inputs();

        // Collision on address 7: port 1 wins
        apply_write(0, 5'd7, 32'h0000_AAAA);
        apply_write(1, 5'd7, 32'h0000_BBBB);
        tick();
        clear_inputs();
        apply_read(0, 5'd7);
        apply_read(1, 5'd7);
        #1;
        check_output("collision", rdata, 64'h0000_BBBB_0000_BBBB);
        clear_inputs();

        apply_write(0, 5'd10, 32'h1010_1010);
        apply_write(1, 5'd11, 32'h1111_1111);
        tick();
        clear_inputs();
        apply_read(0, 5'd10);
        apply_read(1, 5'd11);
        #1;
        check_output("dual_write", rdata, 64'h1111_1111_1010_1010);
        clear_inputs();

        // Register 0 ignores writes and marks; disabled port reads zero
        apply_write(0, 5'd0, 32'h0000_DEAD);
        mark_en   = 1'b1;
        mark_addr = 5'd0;
        tick();
        clear_inputs();
        apply_read(0, 5'd0);
        raddr[9:5] = 5'd7;
        #1;
        check_output("reg0_and_re0_rdata", rdata, 64'd0);
        check_output("reg0_busy", 64'(busy), 64'd0);
        clear_inputs();

        // Scoreboard set, set-beats-clear, clear, flush
        mark_en   = 1'b1;
        mark_addr = 5'd9;
        tick();
        clear_inputs();
        apply_read(0, 5'd9);
        raddr[9:5] = 5'd9;
        #1;
        check_output("mark9_busy", 64'(busy), 64'b01);
        clear_inputs();

        apply_write(1, 5'd9, 32'h0000_0099);
        mark_en   = 1'b1;
        mark_addr = 5'd9;
        tick();
        clear_inputs();
        apply_read(0, 5'd9);
        #1;
        check_output("set_beats_clear", 64'(busy), 64'b01);
        check_output("set_beats_clear_data", rdata, 64'h99);
        clear_inputs();

        apply_write(0, 5'd9, 32'h0000_0999);
        tick();
        clear_inputs();
        apply_read(0, 5'd9);
        #1;
        check_output("write9_clears", 64'(busy), 64'b00);
        check_output("write9_data", rdata, 64'h999);
        clear_inputs();

        mark_en   = 1'b1;
        mark_addr = 5'd3;
        tick();
        mark_addr = 5'd4;
        tick();
        clear_inputs();
        apply_read(0, 5'd3);
        apply_read(1, 5'd4);
        #1;
        check_output("mark3_4_busy", 64'(busy), 64'b11);
        clear_inputs();
        flush = 1'b1;
        tick();
        clear_inputs();
        apply_read(0, 5'd3);
        apply_read(1, 5'd4);
        #1;
        check_output("flush_busy", 64'(busy), 64'b00);
        clear_inputs();

        flush     = 1'b1;
        mark_en   = 1'b1;
        mark_addr = 5'd6;
        tick();
        clear_inputs();
        apply_read(1, 5'd6);
        #1;
        check_output("flush_with_mark", 64'(busy), 64'b10);
        clear_inputs();

        // Same-cycle write/read of a pending register
        apply_write(0, 5'd12, 32'h0000_1111);
        tick();
        clear_inputs();
        mark_en   = 1'b1;
        mark_addr = 5'd12;
        tick();
        clear_inputs();
        apply_write(0, 5'd12, 32'h0000_1234);
        apply_read(0, 5'd12);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_output("bypass_rdata", rdata, 64'h1234);
        check_output("bypass_busy", 64'(busy), 64'b00);
`else
        check_output("nobypass_rdata", rdata, 64'h1111);
        check_output("nobypass_busy", 64'(busy), 64'b01);
`endif
        tick();
        clear_inputs();
        apply_read(0, 5'd12);
        #1;
        check_output("after_write12_rdata", rdata, 64'h1234);
        check_output("after_write12_busy", 64'(busy), 64'b00);
        clear_inputs();

        // Mid-run reset during traffic
        apply_write(0, 5'd20, 32'h0000_ABCD);
        mark_en   = 1'b1;
        mark_addr = 5'd5;
        tick();
        clear_inputs();
        apply_write(1, 5'd21, 32'h0000_2121);
        apply_read(0, 5'd5);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_ready", 64'(ready), 64'd0);
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_rdata", rdata, 64'd0);
        tick();
        clear_inputs();
        rst = 1'b1;
        count_sweep("midrst_sweep_len");
        apply_read(0, 5'd20);
        apply_read(1, 5'd5);
        #1;
        check_output("midrst_cleared", rdata, 64'd0);
        check_output("midrst_pending", 64'(busy), 64'd0);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
